// File: rtl/expr_mem_unit.sv
// Memory-backed expression engine: DEPTH x WIDTH register-file RAM plus a sequencer
// that reads two operands, applies MUL/ADD/SUB/MOV and writes the result back.
// Optional saturating results are enabled by defining EXPR_SAT_EN.
module expr_mem_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              ovf,
  output logic [2:0]        dbg_state_o
);

  // Handshake: start/wr_en are accepted only in IDLE (busy=0); anything offered while
  // busy is dropped. done pulses for exactly one cycle, the same cycle busy falls.
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} state_t;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_MOV = 2'b11;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    mem [DEPTH];
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   src_a_q, src_b_q, dst_q;
  logic [WIDTH-1:0]    a_q, b_q, result_q, rd_data_q;
  logic                ovf_q, done_q;

  logic [2*WIDTH-1:0]  prod;
  logic [WIDTH:0]      sum, diff;
  logic [WIDTH-1:0]    exec_res, raw_res;
  logic                exec_ovf;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RD_A;
      RD_A:    state_d = RD_B;
      RD_B:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prod     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    sum      = {1'b0, a_q} + {1'b0, b_q};
    diff     = {1'b0, a_q} - {1'b0, b_q};  // MSB is the borrow
    raw_res  = a_q;
    exec_ovf = 1'b0;
    case (op_q)
      OP_MUL: begin raw_res = prod[WIDTH-1:0]; exec_ovf = |prod[2*WIDTH-1:WIDTH]; end
      OP_ADD: begin raw_res = sum[WIDTH-1:0];  exec_ovf = sum[WIDTH];             end
      OP_SUB: begin raw_res = diff[WIDTH-1:0]; exec_ovf = diff[WIDTH];            end
      OP_MOV: begin raw_res = a_q;             exec_ovf = 1'b0;                   end
      default: begin raw_res = a_q;            exec_ovf = 1'b0;                   end
    endcase
`ifdef EXPR_SAT_EN
    if (exec_ovf) exec_res = (op_q == OP_SUB) ? '0 : '1;
    else          exec_res = raw_res;
`else
    exec_res = raw_res;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= (state_q == WB);
      rd_data_q <= mem[rd_addr];
      if (state_q == IDLE && start) begin
        op_q    <= op;
        src_a_q <= src_a;
        src_b_q <= src_b;
        dst_q   <= dst;
      end
      if (state_q == RD_A) a_q <= mem[src_a_q];
      if (state_q == RD_B) b_q <= mem[src_b_q];
      if (state_q == EXEC) begin
        result_q <= exec_res;
        ovf_q    <= exec_ovf;
      end
    end
  end

  // RAM is never cleared; reset only suppresses a pending write-back.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && wr_en) mem[wr_addr] <= wr_data;
    else if (state_q == WB && !rst) mem[dst_q] <= result_q;
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign result      = result_q;
  assign ovf         = ovf_q;
  assign rd_data     = rd_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_expr_mem_unit.sv
// Directed, table-driven bench for expr_mem_unit (WIDTH=32, DEPTH=8) with hand-written
// sequences for aliasing, busy-time drops, back-to-back starts and mid-operation reset.
module tb_expr_mem_unit;
  localparam int W = 32;
  localparam int AW = 3;
`ifdef EXPR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [1:0] MUL = 2'b00, ADD = 2'b01, SUB = 2'b10, MOV = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr, rd_addr, src_a, src_b, dst;
  logic [W-1:0]  wr_data, rd_data, result;
  logic          start, busy, done, ovf;
  logic [1:0]    op;
  logic [2:0]    dbg_state;

  int checks = 0;
  int failures = 0;

  expr_mem_unit #(.WIDTH(W), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .dst(dst), .busy(busy), .done(done), .result(result), .ovf(ovf),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_r;
    logic         exp_o;
  } vec_t;
  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_op(input logic [1:0] o, input logic [AW-1:0] sa,
                          input logic [AW-1:0] sb, input logic [AW-1:0] d);
    start = 1'b1; op = o; src_a = sa; src_b = sb; dst = d;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    if (!done) begin
      failures++;
      $display("FAIL done_timeout actual=%0d cycles required=done pulse", n);
    end
  endtask

  task automatic read_chk(input string name, input logic [AW-1:0] a, input logic [W-1:0] e);
    rd_addr = a;
    tick();
    check(name, rd_data, e);
  endtask

  initial begin
    int n;
    vecs[0] = '{MUL, 32'd6, 32'd7, 32'd42, 1'b0};
    vecs[1] = '{ADD, 32'hFFFF_FFFF, 32'd2, SAT ? 32'hFFFF_FFFF : 32'd1, 1'b1};
    vecs[2] = '{SUB, 32'd3, 32'd5, SAT ? 32'd0 : 32'hFFFF_FFFE, 1'b1};
    vecs[3] = '{MUL, 32'h0001_0000, 32'h0001_0000, SAT ? 32'hFFFF_FFFF : 32'd0, 1'b1};
    vecs[4] = '{ADD, 32'd5, 32'd10, 32'd15, 1'b0};
    vecs[5] = '{SUB, 32'd10, 32'd4, 32'd6, 1'b0};
    vecs[6] = '{MOV, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0};
    vecs[7] = '{MUL, 32'hFFFF_FFFF, 32'd2, SAT ? 32'hFFFF_FFFF : 32'hFFFF_FFFE, 1'b1};
    vecs[8] = '{SUB, 32'd7, 32'd7, 32'd0, 1'b0};
    vecs[9] = '{ADD, 32'h8000_0000, 32'h8000_0000, SAT ? 32'hFFFF_FFFF : 32'd0, 1'b1};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    start = 1'b0; op = '0; src_a = '0; src_b = '0; dst = '0;
    tick(); tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_ovf", ovf, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_state", dbg_state, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      wr(3'd0, vecs[i].a);
      wr(3'd1, vecs[i].b);
      start_op(vecs[i].op, 3'd0, 3'd1, 3'd2);
      check($sformatf("v%0d_busy", i), busy, 1);
      wait_done(n);
      check($sformatf("v%0d_latency", i), n, 4);
      check($sformatf("v%0d_result", i), result, vecs[i].exp_r);
      check($sformatf("v%0d_ovf", i), ovf, vecs[i].exp_o);
      check($sformatf("v%0d_busy_at_done", i), busy, 0);
      tick();
      check($sformatf("v%0d_done_pulse", i), done, 0);
      read_chk($sformatf("v%0d_ram_dst", i), 3'd2, vecs[i].exp_r);
    end

    // Aliased operands and destination; rd_data is read-before-write at WB.
    wr(3'd4, 32'd9);
    rd_addr = 3'd4;
    start_op(ADD, 3'd4, 3'd4, 3'd4);
    wait_done(n);
    check("alias_rd_old", rd_data, 32'd9);
    check("alias_result", result, 32'd18);
    tick();
    check("alias_rd_new", rd_data, 32'd18);

    // Same-cycle write and start: operation sees the newly written value.
    wr(3'd1, 32'd11);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'd100;
    start_op(SUB, 3'd0, 3'd1, 3'd3);
    wr_en = 1'b0;
    wait_done(n);
    check("wr_start_result", result, 32'd89);

    // start/wr_en while busy are dropped; start in the done cycle is accepted.
    wr(3'd0, 32'd3);
    wr(3'd1, 32'd4);
    wr(3'd5, 32'hAA);
    wr(3'd6, 32'h66);
    start_op(MUL, 3'd0, 3'd1, 3'd3);
    start = 1'b1; op = ADD; dst = 3'd6;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h55;
    tick();
    start = 1'b0; wr_en = 1'b0;
    wait_done(n);
    check("busy_drop_latency", n, 3);
    check("busy_drop_result", result, 32'd12);
    start_op(ADD, 3'd0, 3'd1, 3'd7);
    check("done_cycle_start_busy", busy, 1);
    check("done_cycle_start_state", dbg_state, 1);
    wait_done(n);
    check("b2b_latency", n, 4);
    check("b2b_result", result, 32'd7);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) n++;
    end
    check("no_extra_done", n, 0);
    read_chk("drop_wr_ram5", 3'd5, 32'hAA);
    read_chk("drop_op_ram6", 3'd6, 32'h66);
    read_chk("mul_ram3", 3'd3, 32'd12);
    read_chk("b2b_ram7", 3'd7, 32'd7);

    // Reset while in EXEC aborts with no write-back.
    wr(3'd2, 32'h77);
    start_op(ADD, 3'd0, 3'd1, 3'd2);
    tick(); tick();
    check("pre_reset_state_exec", dbg_state, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_ovf", ovf, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) n++;
    end
    check("midrst_quiet", n, 0);
    read_chk("midrst_ram_dst", 3'd2, 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
